// File: rtl/uart_packet_tx_if.sv
// uart_packet_tx_if: packet stream in, UART byte handshake out, and status pulses.
//  master: packet source / UART side (drives the stream fields and ipUartBusy)
//  slave : uart_packet_tx (drives opUartData, opUartSend, opTxReady, opFull, opOverflow, opFrameError)
interface uart_packet_tx_if;
   logic [7:0] Source;
   logic [7:0] Destination;
   logic [7:0] Length;
   logic [7:0] Data;
   logic       SoP;
   logic       EoP;
   logic       Valid;
   logic       ipUartBusy;
   logic [7:0] opUartData;
   logic       opUartSend;
   logic       opTxReady;
   logic       opFull;
   logic       opOverflow;
   logic       opFrameError;
   modport master (
      output Source, Destination, Length, Data, SoP, EoP, Valid, ipUartBusy,
      input  opUartData, opUartSend, opTxReady, opFull, opOverflow, opFrameError
   );
   modport slave (
      input  Source, Destination, Length, Data, SoP, EoP, Valid, ipUartBusy,
      output opUartData, opUartSend, opTxReady, opFull, opOverflow, opFrameError
   );
endinterface

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: serialises packets into SYNC/DST/SRC/LEN/payload bytes for a UART transmitter.
//  ipClk : system clock, posedge
//  reset : synchronous active-high reset
//  bus   : uart_packet_tx_if.slave (packet stream in, UART data/send strobe, per-byte ack, status pulses)
module uart_packet_tx #(
   parameter logic [7:0] SYNC_BYTE  = 8'h55,
   parameter int         FIFO_DEPTH = 8
) (
   input logic             ipClk,
   input logic             reset,
   uart_packet_tx_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, SYNC, DEST, SRC, LEN, DATA} state_t;
   state_t      state_q;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wp_q, rp_q;
   logic [7:0]  dst_q, src_q, len_q, rem_q, data_q;
   logic        send_q, rdy_q, ovf_q, ferr_q;
   logic        empty, full, send_ok, pop, push, sop;
   assign empty   = wp_q == rp_q;
   assign full    = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
   // send_q in the guard term covers the UART's one-cycle busy latency
   assign send_ok = !bus.ipUartBusy && !send_q;
   assign pop     = state_q == DATA && !empty && send_ok;
   // a same-cycle pop frees a slot, so a push into a full FIFO is legal then
   assign push    = bus.Valid && (!full || pop);
   assign sop     = bus.Valid && bus.SoP;
   always_ff @(posedge ipClk)
      if (push) mem_q[wp_q[AW-1:0]] <= bus.Data;
   always_ff @(posedge ipClk) begin
      if (reset) begin
         state_q <= IDLE;
         wp_q    <= '0;
         rp_q    <= '0;
         dst_q   <= '0;
         src_q   <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         send_q  <= 1'b0;
         rdy_q   <= 1'b0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         send_q <= 1'b0;
         rdy_q  <= pop;
         ovf_q  <= bus.Valid && !push;
         ferr_q <= sop && state_q != IDLE;
         if (push) wp_q <= wp_q + 1'b1;
         if (pop) rp_q <= rp_q + 1'b1;
         case (state_q)
            IDLE: if (sop) begin
               dst_q   <= bus.Destination;
               src_q   <= bus.Source;
               len_q   <= bus.Length;
               rem_q   <= bus.Length;
               state_q <= SYNC;
            end
            SYNC, DEST, SRC, LEN: if (send_ok) begin
               send_q  <= 1'b1;
               data_q  <= state_q == SYNC ? SYNC_BYTE : state_q == DEST ? dst_q : state_q == SRC ? src_q : len_q;
               state_q <= state_q == SYNC ? DEST : state_q == DEST ? SRC : state_q == SRC ? LEN :
                          len_q == 8'd0 ? IDLE : DATA;
            end
            DATA: if (pop) begin
               send_q <= 1'b1;
               data_q <= mem_q[rp_q[AW-1:0]];
               rem_q  <= rem_q - 8'd1;
               if (rem_q == 8'd1) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.opUartData   = data_q;
   assign bus.opUartSend   = send_q;
   assign bus.opTxReady    = rdy_q;
   assign bus.opFull       = full;
   assign bus.opOverflow   = ovf_q;
   assign bus.opFrameError = ferr_q;
endmodule
